// File: rtl/line_arbiter.sv
// Two-requester cacheline arbiter (dcache priority, icache starvation guard) onto one adaptor port.
// Grant one cycle after request seen in IDLE; one IDLE cycle between transactions; non-owner waits.
module line_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_read,
  input  logic             i_write,
  input  logic [31:0]      i_addr,
  input  logic [255:0]     i_wdata,
  output logic [255:0]     i_rdata,
  output logic             i_resp,
  input  logic             d_read,
  input  logic             d_write,
  input  logic [31:0]      d_addr,
  input  logic [255:0]     d_wdata,
  output logic [255:0]     d_rdata,
  output logic             d_resp,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_addr,
  output logic [255:0]     mem_wdata,
  input  logic [255:0]     mem_rdata,
  input  logic             mem_resp,
  output logic             busy,
  output logic             owner,
  output logic [CNT_W-1:0] i_grant_cnt,
  output logic [CNT_W-1:0] d_grant_cnt
);

  localparam int SW = 4;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   streak, streak_nxt;
  logic [CNT_W-1:0] i_cnt_q, d_cnt_q;
  logic            ireq, dreq;

  assign ireq = i_read | i_write;
  assign dreq = d_read | d_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      streak  <= '0;
      i_cnt_q <= '0;
      d_cnt_q <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
      if (state == IDLE && state_nxt == SERVE_I) i_cnt_q <= i_cnt_q + CNT_W'(1);
      if (state == IDLE && state_nxt == SERVE_D) d_cnt_q <= d_cnt_q + CNT_W'(1);
    end
  end

  // streak counts dcache wins taken while icache was also waiting
  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    case (state)
      IDLE: begin
        if (dreq && (!ireq || streak != LIMIT)) begin
          state_nxt  = SERVE_D;
          streak_nxt = ireq ? ((streak >= LIMIT) ? LIMIT : streak + SW'(1)) : '0;
        end else if (ireq) begin
          state_nxt  = SERVE_I;
          streak_nxt = '0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    case (state)
      SERVE_I: begin
        mem_write = i_write;
        mem_read  = i_read & ~i_write;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        i_resp    = mem_resp;
      end
      SERVE_D: begin
        mem_write = d_write;
        mem_read  = d_read & ~d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_resp    = mem_resp;
      end
      default: ;
    endcase
  end

  assign i_rdata     = mem_rdata;
  assign d_rdata     = mem_rdata;
  assign busy        = (state != IDLE);
  assign owner       = (state == SERVE_D);
  assign i_grant_cnt = i_cnt_q;
  assign d_grant_cnt = d_cnt_q;

endmodule

// File: tb/tb_line_arbiter.sv
// Directed and randomized bench for line_arbiter against a transaction-level reference model.
module tb_line_arbiter;

  localparam int LIM = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_read, i_write, d_read, d_write, mem_resp;
  logic [31:0]  i_addr, d_addr;
  logic [255:0] i_wdata, d_wdata, mem_rdata;
  logic [255:0] i_rdata, d_rdata, mem_wdata;
  logic         i_resp, d_resp, mem_read, mem_write, busy, owner;
  logic [31:0]  mem_addr, i_grant_cnt, d_grant_cnt;

  int checks = 0;
  int failures = 0;

  // reference model: transaction owner, starvation run, grant totals
  bit          m_busy, m_own;
  int          m_streak;
  logic [31:0] m_icnt, m_dcnt;

  line_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy(busy), .owner(owner), .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_streak = 0; m_icnt = '0; m_dcnt = '0;
  endtask

  task automatic check_all(input string ph);
    logic ew, er;
    logic [31:0] ea;
    logic [255:0] ed;
    ew = 0; er = 0; ea = '0; ed = '0;
    if (m_busy && m_own) begin
      ew = d_write; er = d_read && !d_write; ea = d_addr; ed = d_wdata;
    end else if (m_busy) begin
      ew = i_write; er = i_read && !i_write; ea = i_addr; ed = i_wdata;
    end
    chk({ph, ".mem_write"}, mem_write, ew);
    chk({ph, ".mem_read"},  mem_read,  er);
    chk({ph, ".mem_addr"},  mem_addr,  ea);
    chk({ph, ".mem_wdata"}, mem_wdata, ed);
    chk({ph, ".i_resp"},    i_resp,    m_busy && !m_own && mem_resp);
    chk({ph, ".d_resp"},    d_resp,    m_busy && m_own && mem_resp);
    chk({ph, ".i_rdata"},   i_rdata,   mem_rdata);
    chk({ph, ".d_rdata"},   d_rdata,   mem_rdata);
    chk({ph, ".busy"},      busy,      m_busy);
    chk({ph, ".owner"},     owner,     m_busy && m_own);
    chk({ph, ".i_cnt"},     i_grant_cnt, m_icnt);
    chk({ph, ".d_cnt"},     d_grant_cnt, m_dcnt);
  endtask

  // advance one clock; model decision is taken from inputs as seen before the edge
  task automatic tick();
    bit nb, no, ir, dr;
    int ns;
    logic [31:0] ni, nd;
    nb = m_busy; no = m_own; ns = m_streak; ni = m_icnt; nd = m_dcnt;
    ir = (i_read | i_write) === 1'b1;
    dr = (d_read | d_write) === 1'b1;
    if (!m_busy) begin
      if (ir && (!dr || m_streak >= LIM)) begin
        nb = 1; no = 0; ns = 0; ni = m_icnt + 1;
      end else if (dr) begin
        nb = 1; no = 1; nd = m_dcnt + 1;
        ns = ir ? ((m_streak + 1 > LIM) ? LIM : m_streak + 1) : 0;
      end
    end else if (mem_resp) begin
      nb = 0;
    end
    @(posedge clk);
    #1;
    m_busy = nb; m_own = no; m_streak = ns; m_icnt = ni; m_dcnt = nd;
  endtask

  initial begin
    bit i_pend, d_pend, seen_i;
    string ord;
    logic [31:0] d_base;
    logic [1:0] op;

    reset_n = 0;
    i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
    d_read = 1; d_write = 0; d_addr = 32'h0000_3000; d_wdata = '0;
    mem_resp = 0; mem_rdata = '0;
    model_reset();

    // reset held with a pending dcache read
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    chk("rst.mem_read_const", mem_read, 1'b0);
    reset_n = 1;
    tick();
    check_all("rel");
    chk("rel.busy_const", busy, 1'b1);
    chk("rel.owner_const", owner, 1'b1);
    mem_resp = 1; mem_rdata = rand256();
    #1; check_all("rel_resp");
    tick();
    d_read = 0; mem_resp = 0;
    #1; check_all("rel_idle");

    // solo icache read, response 4 cycles after grant
    i_read = 1; i_addr = 32'h0000_1040;
    #1; check_all("iso_req");
    tick();
    for (int k = 0; k < 3; k++) begin
      #1; check_all("iso_wait"); tick();
    end
    mem_resp = 1; mem_rdata = {8{32'hDEADBEEF}};
    #1; check_all("iso_resp");
    chk("iso.mem_addr", mem_addr, 32'h0000_1040);
    chk("iso.i_resp", i_resp, 1'b1);
    chk("iso.i_rdata", i_rdata, {8{32'hDEADBEEF}});
    tick();
    i_read = 0; mem_resp = 0;
    #1; check_all("iso_done");
    chk("iso.i_cnt", i_grant_cnt, 32'd1);
    chk("iso.busy", busy, 1'b0);

    // simultaneous requests: dcache first, icache after one idle cycle
    i_read = 1; i_addr = 32'h0000_5000;
    d_write = 1; d_addr = 32'h0000_2000; d_wdata = rand256();
    tick();
    #1; check_all("pri_d");
    chk("pri.owner", owner, 1'b1);
    chk("pri.mem_write", mem_write, 1'b1);
    chk("pri.mem_wdata", mem_wdata, d_wdata);
    mem_resp = 1;
    #1; check_all("pri_dresp");
    tick();
    d_write = 0; mem_resp = 0;
    #1; check_all("pri_gap");
    chk("pri.gap_busy", busy, 1'b0);
    tick();
    #1; check_all("pri_i");
    chk("pri.i_owner", owner, 1'b0);
    chk("pri.i_busy", busy, 1'b1);
    mem_resp = 1;
    tick();
    i_read = 0; mem_resp = 0;

    // starvation guard: both hold requests continuously
    i_read = 1; d_read = 1; d_addr = 32'h0000_7000;
    ord = ""; seen_i = 0; d_base = m_dcnt;
    for (int g = 0; g < 6; g++) begin
      tick();
      #1; check_all("stv_grant");
      ord = {ord, (owner === 1'b1) ? "D" : "I"};
      if (owner === 1'b0 && !seen_i) begin
        seen_i = 1;
        chk("stv.d_cnt_at_i", d_grant_cnt, d_base + 32'd4);
      end
      mem_resp = 1;
      #1; check_all("stv_resp");
      tick();
      mem_resp = 0;
    end
    checks++;
    assert (ord == "DDDDID") else begin
      failures++;
      $error("FAIL stv.order observed=%s expected=DDDDID", ord);
    end
    i_read = 0; d_read = 0;

    // requester asserting read and write together
    d_read = 1; d_write = 1;
    tick();
    #1; check_all("both");
    chk("both.mem_write", mem_write, 1'b1);
    chk("both.mem_read", mem_read, 1'b0);
    mem_resp = 1;
    tick();
    d_read = 0; d_write = 0; mem_resp = 0;

    // reset pulse during an icache transaction
    i_read = 1; i_addr = 32'h0000_9040;
    tick();
    #1; check_all("mrst_pre");
    reset_n = 0;
    #1;
    model_reset();
    check_all("mrst_low");
    chk("mrst.i_cnt", i_grant_cnt, 32'd0);
    chk("mrst.mem_read", mem_read, 1'b0);
    i_read = 0;
    @(posedge clk);
    #2;
    reset_n = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1; check_all("mrst_idle");
      chk("mrst.busy", busy, 1'b0);
    end

    // randomized traffic, including owner withdrawal and stray mem_resp in IDLE
    i_pend = 0; d_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!i_pend) begin
        if ($urandom_range(0, 2) == 0) begin
          op = 2'($urandom_range(1, 3));
          i_read = op[0]; i_write = op[1]; i_addr = $urandom; i_wdata = rand256(); i_pend = 1;
        end else begin
          i_read = 0; i_write = 0;
        end
      end else if (m_busy && !m_own && $urandom_range(0, 19) == 0) begin
        i_read = 0; i_write = 0;
      end
      if (!d_pend) begin
        if ($urandom_range(0, 1) == 0) begin
          op = 2'($urandom_range(1, 3));
          d_read = op[0]; d_write = op[1]; d_addr = $urandom; d_wdata = rand256(); d_pend = 1;
        end else begin
          d_read = 0; d_write = 0;
        end
      end else if (m_busy && m_own && $urandom_range(0, 19) == 0) begin
        d_read = 0; d_write = 0;
      end
      mem_resp = ($urandom_range(0, 2) == 0);
      mem_rdata = rand256();
      #1; check_all("rnd");
      if (m_busy && mem_resp) begin
        if (m_own) d_pend = 0;
        else i_pend = 0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
